// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor sequencer: diff = (a - b) mod 2^WIDTH, LSB first through one subtract cell.
// Latency: WIDTH cycles from the accepting edge to done; back-to-back period WIDTH+1 cycles.
// Backpressure: none; start is only honoured in IDLE/DONE and ignored while busy. Optional eq/lt outputs under SERIAL_SUB_CMP_EN.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_CMP_EN
  ,
  output logic             eq,
  output logic             lt
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
`ifdef SERIAL_SUB_CMP_EN
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
`endif

  // One-bit subtract cell: the borrow flop is cleared on accept, so bit 0 behaves as a half subtractor.
  logic bit_x, bit_y, bit_d, brw_nxt;
  always_comb begin
    bit_x   = a_sr_q[0];
    bit_y   = b_sr_q[0];
    bit_d   = bit_x ^ bit_y ^ brw_q;
    brw_nxt = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & brw_q);
  end

  // Sequencer next-state: accept/load, per-bit shift, and result capture on the last bit.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_CMP_EN
    eq_d    = eq_q;
    lt_d    = lt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          brw_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_sr_d            = a_sr_q >> 1;
        b_sr_d            = b_sr_q >> 1;
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = bit_d;
        brw_d             = brw_nxt;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Final bit: the result register is complete after this shift.
          state_d = S_DONE;
          diff_d  = res_d;
          bo_d    = brw_nxt;
`ifdef SERIAL_SUB_CMP_EN
          eq_d    = (res_d == '0);
          lt_d    = brw_nxt;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUB_CMP_EN
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUB_CMP_EN
      eq_q    <= eq_d;
      lt_q    <= lt_d;
`endif
    end
  end

  // Status outputs decode directly from the state flop.
  always_comb begin
    busy       = (state_q == S_SHIFT);
    done       = (state_q == S_DONE);
    diff       = diff_q;
    borrow_out = bo_q;
`ifdef SERIAL_SUB_CMP_EN
    eq         = eq_q;
    lt         = lt_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl: WIDTH=8 instance plus a WIDTH=1 instance.
// Expected results are queued when an operation is issued and popped when done is seen.
// All outputs are sampled on the falling clock edge.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, borrow_out;
  logic [7:0] diff;
`ifdef SERIAL_SUB_CMP_EN
  logic       eq, lt;
`endif

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, borrow_out1;
  logic [0:0] diff1;
`ifdef SERIAL_SUB_CMP_EN
  logic       eq1, lt1;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       eq;
    logic       lt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_CMP_EN
    , .eq(eq), .lt(lt)
`endif
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow_out1)
`ifdef SERIAL_SUB_CMP_EN
    , .eq(eq1), .lt(lt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    e.d  = av - bv;
    e.bo = (av < bv);
    e.eq = (av == bv);
    e.lt = (av < bv);
    sb.push_back(e);
  endtask

  // Waits (bounded) for done at a falling edge, then pops and compares the scoreboard head.
  task automatic wait_done(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_timeout"}, (lat < 40), 1);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_done"}, 0, 1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_diff"}, diff, e.d);
        chk({tag, "_borrow"}, borrow_out, e.bo);
`ifdef SERIAL_SUB_CMP_EN
        chk({tag, "_eq"}, eq, e.eq);
        chk({tag, "_lt"}, lt, e.lt);
`endif
      end
    end else begin
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  // Issues one operation with a one-cycle start and checks result and latency.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv);
    int lat;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    push_exp(av, bv);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(tag, lat);
    chk({tag, "_latency"}, lat, 8);
  endtask

  initial begin
    int lat;
    int ndone;
    int t_prev;
    logic [7:0] pa[3];
    logic [7:0] pb[3];
    logic [0:0] ta[4];
    logic [0:0] tb[4];
    logic [0:0] td[4];
    logic [0:0] tbo[4];

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Basic cases and borrow corner cases.
    run_op("op9m3", 8'd9, 8'd3);
    run_op("op3m9", 8'd3, 8'd9);
    run_op("op55", 8'h55, 8'h55);
    run_op("op00mff", 8'h00, 8'hFF);
    run_op("opffm00", 8'hFF, 8'h00);

    // Start pulsed mid-operation must be ignored.
    @(negedge clk);
    a = 8'd200;
    b = 8'd100;
    start = 1'b1;
    push_exp(8'd200, 8'd100);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("midstart", lat);
    chk("midstart_latency", lat + 4, 8);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midstart_extra_done", ndone, 0);
    chk("midstart_sb_empty", sb.size(), 0);

    // Asynchronous reset mid-SHIFT discards the operation.
    @(negedge clk);
    a = 8'd50;
    b = 8'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_diff_held", diff, 8'd100);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_diff", diff, 0);
    chk("arst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_CMP_EN
    chk("arst_eq", eq, 0);
    chk("arst_lt", lt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    run_op("op7m2", 8'd7, 8'd2);

    // Back-to-back stream with start held high.
    pa[0] = 8'd40;  pb[0] = 8'd15;
    pa[1] = 8'd15;  pb[1] = 8'd40;
    pa[2] = 8'hA5;  pb[2] = 8'hA5;
    @(negedge clk);
    a = pa[0];
    b = pb[0];
    start = 1'b1;
    push_exp(pa[0], pb[0]);
    @(negedge clk);
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        a = pa[k+1];
        b = pb[k+1];
        push_exp(pa[k+1], pb[k+1]);
      end else begin
        start = 1'b0;
      end
      wait_done($sformatf("b2b%0d", k), lat);
      chk($sformatf("b2b%0d_latency", k), lat, 8);
      if (k > 0) chk($sformatf("b2b%0d_spacing", k), cyc - t_prev, 9);
      t_prev = cyc;
      @(negedge clk);
    end
    chk("b2b_sb_empty", sb.size(), 0);
    chk("b2b_idle", busy, 0);

    // WIDTH=1 exhaustive half-subtractor table.
    ta[0] = 1'b0; tb[0] = 1'b0; td[0] = 1'b0; tbo[0] = 1'b0;
    ta[1] = 1'b0; tb[1] = 1'b1; td[1] = 1'b1; tbo[1] = 1'b1;
    ta[2] = 1'b1; tb[2] = 1'b0; td[2] = 1'b1; tbo[2] = 1'b0;
    ta[3] = 1'b1; tb[3] = 1'b1; td[3] = 1'b0; tbo[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = ta[i];
      b1 = tb[i];
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk($sformatf("w1_%0d_busy", i), busy1, 1);
      @(negedge clk);
      chk($sformatf("w1_%0d_done", i), done1, 1);
      chk($sformatf("w1_%0d_diff", i), diff1, td[i]);
      chk($sformatf("w1_%0d_borrow", i), borrow_out1, tbo[i]);
`ifdef SERIAL_SUB_CMP_EN
      chk($sformatf("w1_%0d_eq", i), eq1, (ta[i] == tb[i]));
      chk($sformatf("w1_%0d_lt", i), lt1, tbo[i]);
`endif
      @(negedge clk);
      chk($sformatf("w1_%0d_done_fall", i), done1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
